// File: rtl/decoder_addr_sequencer.sv
// Address sequencer feeding a one-hot decoder: walks A from a commanded start to end
// (modulo 2**AW), holding each address for a programmable dwell, once or looping until abort.
module decoder_addr_sequencer #(
    parameter int unsigned AW      = 5,
    parameter int unsigned DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [AW-1:0]      cmd_start,
    input  logic [AW-1:0]      cmd_end,
    input  logic [DWELL_W-1:0] cmd_dwell,
    input  logic               cmd_loop,
    input  logic               abort,
    output logic [AW-1:0]      A,
    output logic               A_valid,
    output logic               busy,
    output logic               done,
    output logic               aborted,
    output logic               wrap
);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    logic               state_q, state_d;
    logic [AW-1:0]      start_q, start_d;
    logic [AW-1:0]      end_q, end_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               loop_q, loop_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [AW-1:0]      a_q, a_d;
    logic               a_valid_q, a_valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               aborted_q, aborted_d;
    logic               wrap_q, wrap_d;
    logic               accept;

    assign cmd_ready = (state_q == ST_IDLE) && !rst;
    assign accept    = cmd_valid && cmd_ready;

    always_comb begin
        state_d   = state_q;
        start_d   = start_q;
        end_d     = end_q;
        dwell_d   = dwell_q;
        loop_d    = loop_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        a_valid_d = a_valid_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        aborted_d = 1'b0;
        wrap_d    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    start_d   = cmd_start;
                    end_d     = cmd_end;
                    dwell_d   = cmd_dwell;
                    loop_d    = cmd_loop;
                    cnt_d     = cmd_dwell;
                    a_d       = cmd_start;
                    a_valid_d = 1'b1;
                    busy_d    = 1'b1;
                    state_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                // Abort has priority over any step, wrap or completion in the same cycle.
                if (abort) begin
                    state_d   = ST_IDLE;
                    a_valid_d = 1'b0;
                    busy_d    = 1'b0;
                    aborted_d = 1'b1;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - DWELL_W'(1);
                end else if (a_q != end_q) begin
                    a_d   = a_q + AW'(1);
                    cnt_d = dwell_q;
                end else if (loop_q) begin
                    a_d    = start_q;
                    cnt_d  = dwell_q;
                    wrap_d = 1'b1;
                end else begin
                    // A keeps its last value; only the qualifier drops.
                    state_d   = ST_IDLE;
                    a_valid_d = 1'b0;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            start_q   <= '0;
            end_q     <= '0;
            dwell_q   <= '0;
            loop_q    <= 1'b0;
            cnt_q     <= '0;
            a_q       <= '0;
            a_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            start_q   <= start_d;
            end_q     <= end_d;
            dwell_q   <= dwell_d;
            loop_q    <= loop_d;
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            a_valid_q <= a_valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
            wrap_q    <= wrap_d;
        end
    end

    assign A       = a_q;
    assign A_valid = a_valid_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign aborted = aborted_q;
    assign wrap    = wrap_q;

endmodule

// File: tb/tb_decoder_addr_sequencer.sv
// Directed bench for decoder_addr_sequencer: inputs change and outputs are checked 1ns
// after each rising edge, against hand-computed expectations.
module tb_decoder_addr_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [4:0] cmd_start;
    logic [4:0] cmd_end;
    logic [7:0] cmd_dwell;
    logic       cmd_loop;
    logic       abort;
    logic [4:0] A;
    logic       A_valid;
    logic       busy;
    logic       done;
    logic       aborted;
    logic       wrap;

    int n_checks = 0;
    int n_fail   = 0;

    decoder_addr_sequencer #(
        .AW      (5),
        .DWELL_W (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_start (cmd_start),
        .cmd_end   (cmd_end),
        .cmd_dwell (cmd_dwell),
        .cmd_loop  (cmd_loop),
        .abort     (abort),
        .A         (A),
        .A_valid   (A_valid),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted),
        .wrap      (wrap)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Presents one command for a single edge; it is accepted when the sequencer is idle.
    task automatic send(input logic [4:0] s, input logic [4:0] e, input logic [7:0] d,
                        input logic l);
        cmd_start = s;
        cmd_end   = e;
        cmd_dwell = d;
        cmd_loop  = l;
        cmd_valid = 1'b1;
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL send_ready: cmd_ready=%b want 1", cmd_ready);
        end
        cyc();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc();
        cyc();
        n_checks++;
        if ({cmd_ready, A, A_valid, busy, done, aborted, wrap} !== 11'b0) begin
            n_fail++;
            $display("FAIL reset_state: rdy=%b A=%0d v=%b busy=%b done=%b abt=%b wrap=%b want all 0",
                     cmd_ready, A, A_valid, busy, done, aborted, wrap);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: cmd_ready=%b want 1", cmd_ready);
        end
    endtask

    task automatic test_idle_abort();
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        n_checks++;
        if ({aborted, busy, A_valid, cmd_ready} !== 4'b0001) begin
            n_fail++;
            $display("FAIL idle_abort: abt=%b busy=%b v=%b rdy=%b want 0 0 0 1",
                     aborted, busy, A_valid, cmd_ready);
        end
    endtask

    task automatic test_basic();
        send(5'd3, 5'd6, 8'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (A !== 5'(3 + i) || A_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0
                || cmd_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL basic_run[%0d]: A=%0d v=%b busy=%b done=%b rdy=%b want A=%0d 1 1 0 0",
                         i, A, A_valid, busy, done, cmd_ready, 3 + i);
            end
            cyc();
        end
        n_checks++;
        if (done !== 1'b1 || A_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1
            || A !== 5'd6) begin
            n_fail++;
            $display("FAIL basic_done: done=%b v=%b busy=%b rdy=%b A=%0d want 1 0 0 1 A=6",
                     done, A_valid, busy, cmd_ready, A);
        end
        cyc();
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done_pulse: done=%b want 0", done);
        end
    endtask

    task automatic test_wrap_dwell();
        logic [4:0] exp_a [8] = '{5'd30, 5'd30, 5'd31, 5'd31, 5'd0, 5'd0, 5'd1, 5'd1};
        send(5'd30, 5'd1, 8'd1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (A !== exp_a[i] || A_valid !== 1'b1 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL wrap_dwell[%0d]: A=%0d v=%b done=%b want A=%0d 1 0",
                         i, A, A_valid, done, exp_a[i]);
            end
            cyc();
        end
        n_checks++;
        if (done !== 1'b1 || A_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_dwell_done: done=%b v=%b want 1 0", done, A_valid);
        end
        cyc();
    endtask

    task automatic test_loop_abort();
        send(5'd5, 5'd5, 8'd2, 1'b1);
        // Step cycles fall at i=2,5,8; wrap is visible at i=3,6. Abort lands on step i=8.
        for (int i = 0; i < 9; i++) begin
            n_checks++;
            if (A !== 5'd5 || A_valid !== 1'b1 || done !== 1'b0
                || wrap !== ((i == 3) || (i == 6))) begin
                n_fail++;
                $display("FAIL loop_run[%0d]: A=%0d v=%b done=%b wrap=%b want A=5 1 0 %b",
                         i, A, A_valid, done, wrap, (i == 3) || (i == 6));
            end
            if (i == 8) abort = 1'b1;
            cyc();
        end
        abort = 1'b0;
        n_checks++;
        if (aborted !== 1'b1 || A_valid !== 1'b0 || busy !== 1'b0 || wrap !== 1'b0
            || done !== 1'b0 || cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL loop_abort: abt=%b v=%b busy=%b wrap=%b done=%b rdy=%b want 1 0 0 0 0 1",
                     aborted, A_valid, busy, wrap, done, cmd_ready);
        end
        cyc();
        n_checks++;
        if (aborted !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL loop_abort_pulse: abt=%b done=%b want 0 0", aborted, done);
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] exp_a [4] = '{5'd8, 5'd8, 5'd9, 5'd9};
        send(5'd8, 5'd9, 8'd1, 1'b0);
        cmd_start = 5'd20;
        cmd_end   = 5'd21;
        cmd_dwell = 8'd0;
        cmd_loop  = 1'b1;
        cmd_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (A !== exp_a[i] || A_valid !== 1'b1 || cmd_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_run[%0d]: A=%0d v=%b rdy=%b want A=%0d 1 0",
                         i, A, A_valid, cmd_ready, exp_a[i]);
            end
            cyc();
        end
        // The held command now carries loop=0 and is taken in the done cycle.
        cmd_loop = 1'b0;
        n_checks++;
        if (done !== 1'b1 || cmd_ready !== 1'b1 || A_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_done: done=%b rdy=%b v=%b want 1 1 0", done, cmd_ready, A_valid);
        end
        cyc();
        cmd_valid = 1'b0;
        n_checks++;
        if (A !== 5'd20 || A_valid !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_second_first: A=%0d v=%b busy=%b want A=20 1 1", A, A_valid, busy);
        end
        cyc();
        n_checks++;
        if (A !== 5'd21 || A_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_second_last: A=%0d v=%b want A=21 1", A, A_valid);
        end
        cyc();
        n_checks++;
        if (done !== 1'b1 || wrap !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_second_done: done=%b wrap=%b want 1 0", done, wrap);
        end
        cyc();
    endtask

    task automatic test_reset_mid_run();
        send(5'd8, 5'd15, 8'd0, 1'b0);
        cyc();
        cyc();
        n_checks++;
        if (A !== 5'd10 || A_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_pre: A=%0d v=%b want A=10 1", A, A_valid);
        end
        rst = 1'b1;
        cyc();
        n_checks++;
        if (A !== 5'd0 || A_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0
            || aborted !== 1'b0 || cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid: A=%0d v=%b busy=%b done=%b abt=%b rdy=%b want 0 0 0 0 0 0",
                     A, A_valid, busy, done, aborted, cmd_ready);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_checks++;
            if (done !== 1'b0 || aborted !== 1'b0 || A_valid !== 1'b0 || cmd_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL rst_mid_after[%0d]: done=%b abt=%b v=%b rdy=%b want 0 0 0 1",
                         i, done, aborted, A_valid, cmd_ready);
            end
        end
    endtask

    task automatic test_long_dwell();
        int n_high = 0;
        send(5'd0, 5'd0, 8'd255, 1'b0);
        for (int i = 0; i < 256; i++) begin
            if (A_valid === 1'b1 && A === 5'd0) n_high++;
            if (i == 255) abort = 1'b1;
            cyc();
        end
        abort = 1'b0;
        n_checks++;
        if (n_high !== 256) begin
            n_fail++;
            $display("FAIL long_dwell_len: valid cycles=%0d want 256", n_high);
        end
        n_checks++;
        if (aborted !== 1'b1 || done !== 1'b0 || A_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL long_dwell_abort: abt=%b done=%b v=%b want 1 0 0",
                     aborted, done, A_valid);
        end
        cyc();
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL long_dwell_no_done: done=%b want 0", done);
        end
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_start = '0;
        cmd_end   = '0;
        cmd_dwell = '0;
        cmd_loop  = 1'b0;
        abort     = 1'b0;
        #1;
        test_reset();
        test_idle_abort();
        test_basic();
        test_wrap_dwell();
        test_loop_abort();
        test_back_to_back();
        test_reset_mid_run();
        test_long_dwell();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Safety net against a stalled run.
    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
